// File: rtl/risc_isa_pkg.sv
// Instruction-set constants shared by the program loader and the instruction decoder.
// Covers opcode values, the R/I-type split point and the 16-bit word field layout.
package risc_isa_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;

    // Opcodes below this value are R-type; the rest carry a 4-bit immediate.
    localparam logic [3:0] R_TYPE_LIMIT = 4'b0101;

    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RS_LSB     = 8;
    localparam int unsigned RT_LSB     = 4;
    localparam int unsigned LOW_LSB    = 0;
    localparam int unsigned FIELD_W    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } loader_state_e;

    function automatic logic is_r_type(input logic [3:0] opcode);
        return opcode < R_TYPE_LIMIT;
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer from instruction fields to a 16-bit instruction word.
// Flags I-type immediates that do not fit the 4-bit field; the word keeps the low nibble.
module instr_encoder
    import risc_isa_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  rs_i,
    input  logic [3:0]  rt_i,
    input  logic [3:0]  rd_i,
    input  logic [7:0]  imm_i,
    output logic [15:0] word_o,
    output logic        imm_err_o
);

    always_comb begin
        word_o                          = '0;
        imm_err_o                       = 1'b0;
        word_o[OPCODE_LSB +: FIELD_W]   = opcode_i;
        word_o[RS_LSB +: FIELD_W]       = rs_i;
        word_o[RT_LSB +: FIELD_W]       = rt_i;
        if (is_r_type(opcode_i)) begin
            word_o[LOW_LSB +: FIELD_W] = rd_i;
        end else begin
            word_o[LOW_LSB +: FIELD_W] = imm_i[3:0];
            imm_err_o                  = |imm_i[7:4];
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams encoded instructions into instruction memory, one registered write per accepted beat.
// A load runs from start until in_last or until DEPTH words have been written.
module program_loader
    import risc_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [3:0]        in_rd,
    input  logic [7:0]        in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              imm_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              full_q, full_d;
    logic              imm_err_q, imm_err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;

    logic [15:0]       enc_word;
    logic              enc_err;
    logic              accept;

    instr_encoder u_encoder (
        .opcode_i  (in_opcode),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .imm_i     (in_imm),
        .word_o    (enc_word),
        .imm_err_o (enc_err)
    );

    assign in_ready = (state_q == StLoad) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        full_d      = full_q;
        imm_err_d   = imm_err_q;
        mem_we_d    = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (accept) begin
            mem_addr_d  = ptr_q[ADDR_W-1:0];
            mem_wdata_d = enc_word;
            ptr_d       = ptr_q + 1'b1;
            if (enc_err) begin
                imm_err_d = 1'b1;
            end
            if (in_last) begin
                state_d = StDone;
            end else if (ptr_q == LAST_PTR) begin
                state_d = StDone;
                full_d  = 1'b1;
            end
        end

        // accept is already masked by start, so a restart never collides with a write here.
        if (start) begin
            state_d   = StLoad;
            ptr_d     = '0;
            full_d    = 1'b0;
            imm_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            full_q      <= 1'b0;
            imm_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            imm_err_q   <= imm_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q == StLoad);
    assign done       = (state_q == StDone);
    assign full       = full_q;
    assign imm_err    = imm_err_q;
    assign word_count = ptr_q;

endmodule
